// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, Zicsr op codes,
// mstatus bit positions and the read-modify-write data function.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

    typedef enum logic [2:0] {
        OpRw  = 3'b001,
        OpRs  = 3'b010,
        OpRc  = 3'b011,
        OpRwi = 3'b101,
        OpRsi = 3'b110,
        OpRci = 3'b111
    } csr_op_e;

    function automatic logic [31:0] csr_wdata(input csr_op_e op, input logic [31:0] old,
                                              input logic [31:0] src);
        logic [31:0] res;
        case (op)
            OpRw, OpRwi: res = src;
            OpRs, OpRsi: res = old | src;
            OpRc, OpRci: res = old & ~src;
            default:     res = old;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_controller.sv
// Machine-mode CSR file: Zicsr read/modify/write, trap entry capture and mret
// restore of the global interrupt enable.
module csr_controller
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [2:0]  op_i,
    input  logic [11:0] addr_i,
    input  logic [31:0] rs1_data_i,
    input  logic [4:0]  zimm_i,
    input  logic        we_i,
    input  logic [31:0] pc_i,
    input  logic        trap_i,
    input  logic [31:0] mcause_i,
    input  logic        mret_i,
    output logic [31:0] rdata_o,
    output logic        illegal_o,
    output logic [31:0] mie_o,
    output logic        mstatus_mie_o,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        int_rst_o
);

    logic        mstatus_mie_q;
    logic        mstatus_mpie_q;
    logic [31:0] mie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;

    logic        addr_valid;
    logic        op_valid;
    logic [31:0] mstatus_rd;
    logic [31:0] src;
    logic [31:0] wdata;
    logic        csr_wr;

    always_comb begin
        mstatus_rd = 32'h0;
        mstatus_rd[MSTATUS_MIE_BIT]  = mstatus_mie_q;
        mstatus_rd[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
    end

    // Read mux; unimplemented addresses read as zero.
    always_comb begin
        addr_valid = 1'b1;
        rdata_o    = 32'h0;
        case (addr_i)
            CSR_MSTATUS:  rdata_o = mstatus_rd;
            CSR_MIE:      rdata_o = mie_q;
            CSR_MTVEC:    rdata_o = mtvec_q;
            CSR_MSCRATCH: rdata_o = mscratch_q;
            CSR_MEPC:     rdata_o = mepc_q;
            CSR_MCAUSE:   rdata_o = mcause_q;
            default:      addr_valid = 1'b0;
        endcase
    end

    always_comb begin
        case (op_i)
            OpRw, OpRs, OpRc, OpRwi, OpRsi, OpRci: op_valid = 1'b1;
            default:                               op_valid = 1'b0;
        endcase
    end

    assign illegal_o = we_i & ~(addr_valid & op_valid);
    assign src       = op_i[2] ? {27'b0, zimm_i} : rs1_data_i;
    assign wdata     = csr_wdata(csr_op_e'(op_i), rdata_o, src);
    // A trapping instruction does not retire, so its CSR write is dropped.
    assign csr_wr    = we_i & ~illegal_o & ~trap_i;
    assign int_rst_o = mret_i & ~trap_i;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
        end else if (trap_i) begin
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
        end else if (mret_i) begin
            // mret overrides any concurrent write to mstatus.
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
        end else if (csr_wr && addr_i == CSR_MSTATUS) begin
            mstatus_mie_q  <= wdata[MSTATUS_MIE_BIT];
            mstatus_mpie_q <= wdata[MSTATUS_MPIE_BIT];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mie_q <= 32'h0;
        end else if (csr_wr && addr_i == CSR_MIE) begin
            mie_q <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mtvec_q <= MTVEC_RST & ~32'h3;
        end else if (csr_wr && addr_i == CSR_MTVEC) begin
            mtvec_q <= wdata & ~32'h3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mscratch_q <= 32'h0;
        end else if (csr_wr && addr_i == CSR_MSCRATCH) begin
            mscratch_q <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mepc_q <= 32'h0;
        end else if (trap_i) begin
            mepc_q <= pc_i & ~32'h3;
        end else if (csr_wr && addr_i == CSR_MEPC) begin
            mepc_q <= wdata & ~32'h3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mcause_q <= 32'h0;
        end else if (trap_i) begin
            mcause_q <= mcause_i;
        end else if (csr_wr && addr_i == CSR_MCAUSE) begin
            mcause_q <= wdata;
        end
    end

    assign mie_o         = mie_q;
    assign mstatus_mie_o = mstatus_mie_q;
    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;

endmodule

// File: tb/tb_csr_controller.sv
// Directed self-checking bench for csr_controller.
module tb_csr_controller;

    localparam logic [31:0] MTVEC_RST = 32'h0000_0107;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  op_i;
    logic [11:0] addr_i;
    logic [31:0] rs1_data_i;
    logic [4:0]  zimm_i;
    logic        we_i;
    logic [31:0] pc_i;
    logic        trap_i;
    logic [31:0] mcause_i;
    logic        mret_i;
    logic [31:0] rdata_o;
    logic        illegal_o;
    logic [31:0] mie_o;
    logic        mstatus_mie_o;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        int_rst_o;

    int n_checks = 0;
    int n_pass   = 0;

    csr_controller #(.MTVEC_RST(MTVEC_RST)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .op_i          (op_i),
        .addr_i        (addr_i),
        .rs1_data_i    (rs1_data_i),
        .zimm_i        (zimm_i),
        .we_i          (we_i),
        .pc_i          (pc_i),
        .trap_i        (trap_i),
        .mcause_i      (mcause_i),
        .mret_i        (mret_i),
        .rdata_o       (rdata_o),
        .illegal_o     (illegal_o),
        .mie_o         (mie_o),
        .mstatus_mie_o (mstatus_mie_o),
        .mtvec_o       (mtvec_o),
        .mepc_o        (mepc_o),
        .int_rst_o     (int_rst_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_i = 1'b0; op_i = 3'b000; addr_i = 12'h0; rs1_data_i = 32'h0; zimm_i = 5'h0;
        pc_i = 32'h0; trap_i = 1'b0; mcause_i = 32'h0; mret_i = 1'b0;
    endtask

    // Drive a CSR instruction for the current cycle and let combinational outputs settle.
    task automatic csr_op(input logic [2:0] op, input logic [11:0] addr,
                          input logic [31:0] rs1, input logic [4:0] zimm);
        we_i = 1'b1; op_i = op; addr_i = addr; rs1_data_i = rs1; zimm_i = zimm;
        #1;
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        we_i = 1'b0; addr_i = addr;
        #1;
        check(tag, rdata_o, exp);
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        mret_i = 1'b1;
        #1;
        check("int_rst_in_reset", {31'b0, int_rst_o}, 32'h1);
        tick();
        tick();
        idle();
        rstn = 1'b1;
        #1;

        check("rst_mie_o", mie_o, 32'h0);
        check("rst_mstatus_mie_o", {31'b0, mstatus_mie_o}, 32'h0);
        check("rst_mepc_o", mepc_o, 32'h0);
        check("rst_mtvec_o", mtvec_o, 32'h0000_0104);
        rd("rst_mstatus", 12'h300, 32'h0);
        rd("rst_mie", 12'h304, 32'h0);
        rd("rst_mtvec", 12'h305, 32'h0000_0104);
        rd("rst_mscratch", 12'h340, 32'h0);
        rd("rst_mepc", 12'h341, 32'h0);
        rd("rst_mcause", 12'h342, 32'h0);

        csr_op(3'b001, 12'h7C0, 32'hDEAD_BEEF, 5'h0);
        check("illegal_addr", {31'b0, illegal_o}, 32'h1);
        check("illegal_addr_rdata", rdata_o, 32'h0);
        csr_op(3'b000, 12'h340, 32'hFFFF_FFFF, 5'h0);
        check("illegal_op", {31'b0, illegal_o}, 32'h1);
        tick();
        idle();
        rd("illegal_no_write", 12'h340, 32'h0);
        csr_op(3'b001, 12'h340, 32'hA5A5_A5A5, 5'h0);
        check("legal_not_illegal", {31'b0, illegal_o}, 32'h0);
        tick();
        idle();
        rd("mscratch_wr", 12'h340, 32'hA5A5_A5A5);

        csr_op(3'b001, 12'h304, 32'hFFFF_0F0F, 5'h0);
        check("mie_rw_old", rdata_o, 32'h0);
        tick();
        csr_op(3'b010, 12'h304, 32'h0000_00F0, 5'h0);
        check("mie_rs_old", rdata_o, 32'hFFFF_0F0F);
        tick();
        csr_op(3'b011, 12'h304, 32'h0F00_0000, 5'h0);
        check("mie_rc_old", rdata_o, 32'hFFFF_0FFF);
        tick();
        idle();
        #1;
        check("mie_o_final", mie_o, 32'hF0FF_0FFF);

        csr_op(3'b110, 12'h300, 32'hFFFF_FFFF, 5'd8);
        check("mstatus_rsi_old", rdata_o, 32'h0);
        tick();
        idle();
        #1;
        check("mstatus_mie_set", {31'b0, mstatus_mie_o}, 32'h1);
        rd("mstatus_after_rsi", 12'h300, 32'h0000_0008);

        csr_op(3'b001, 12'h340, 32'h1234_5678, 5'h0);
        trap_i = 1'b1; pc_i = 32'h0000_0123; mcause_i = 32'd5;
        #1;
        check("trap_no_ack", {31'b0, int_rst_o}, 32'h0);
        tick();
        idle();
        #1;
        check("trap_mepc_o", mepc_o, 32'h0000_0120);
        check("trap_mie_clr", {31'b0, mstatus_mie_o}, 32'h0);
        rd("trap_mepc", 12'h341, 32'h0000_0120);
        rd("trap_mcause", 12'h342, 32'd5);
        rd("trap_mstatus", 12'h300, 32'h0000_0080);
        rd("trap_mscratch_kept", 12'h340, 32'hA5A5_A5A5);

        mret_i = 1'b1;
        #1;
        check("mret_ack", {31'b0, int_rst_o}, 32'h1);
        tick();
        idle();
        #1;
        check("mret_ack_drop", {31'b0, int_rst_o}, 32'h0);
        rd("mret_mstatus", 12'h300, 32'h0000_0088);

        trap_i = 1'b1; mret_i = 1'b1; pc_i = 32'h0000_2002; mcause_i = 32'h8000_000B;
        #1;
        check("trap_mret_no_ack", {31'b0, int_rst_o}, 32'h0);
        tick();
        idle();
        rd("trap_mret_mstatus", 12'h300, 32'h0000_0080);
        check("trap_mret_mepc", mepc_o, 32'h0000_2000);
        rd("trap_mret_mcause", 12'h342, 32'h8000_000B);

        csr_op(3'b001, 12'h305, 32'h0000_1003, 5'h0);
        tick();
        idle();
        #1;
        check("mtvec_align", mtvec_o, 32'h0000_1000);

        csr_op(3'b001, 12'h341, 32'h0000_3337, 5'h0);
        tick();
        idle();
        #1;
        check("mepc_wr_align", mepc_o, 32'h0000_3334);

        // mret alongside a write to mstatus: mret result wins.
        csr_op(3'b001, 12'h300, 32'h0000_0000, 5'h0);
        mret_i = 1'b1;
        #1;
        check("mret_wr_old", rdata_o, 32'h0000_0080);
        check("mret_wr_ack", {31'b0, int_rst_o}, 32'h1);
        tick();
        idle();
        rd("mret_wr_mstatus", 12'h300, 32'h0000_0088);
        check("mret_wr_mepc", mepc_o, 32'h0000_3334);

        csr_op(3'b011, 12'h342, 32'h0, 5'h0);
        check("rc_zero_old", rdata_o, 32'h8000_000B);
        tick();
        idle();
        rd("rc_zero_kept", 12'h342, 32'h8000_000B);

        csr_op(3'b111, 12'h300, 32'h0, 5'd8);
        tick();
        idle();
        rd("rci_mstatus", 12'h300, 32'h0000_0080);

        csr_op(3'b001, 12'h304, 32'h1111_1111, 5'h0);
        trap_i = 1'b1; pc_i = 32'h0000_4444; mcause_i = 32'd7;
        rstn = 1'b0;
        tick();
        idle();
        rstn = 1'b1;
        #1;
        check("mid_rst_mie_o", mie_o, 32'h0);
        check("mid_rst_mepc_o", mepc_o, 32'h0);
        check("mid_rst_mtvec_o", mtvec_o, 32'h0000_0104);
        rd("mid_rst_mstatus", 12'h300, 32'h0);
        rd("mid_rst_mcause", 12'h342, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/csr_controller.md
# csr_controller

Machine-mode CSR file for the RV32 core. Executes Zicsr instructions (CSRRW/S/C and immediate forms) and updates trap state on interrupt entry and `mret`. Sits between the decoder/datapath and the interrupt controller:

- It supplies the interrupt-enable mask to the interrupt controller and returns the acknowledge pulse on `mret`.
- It captures the cause code and return address when the core takes an interrupt.

## Interface
Parameters:
- `MTVEC_RST`, 32'h0000_0000, reset value of `mtvec`.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rstn`  in  1  reset, synchronous, active-low.
- `op_i`  in  3  CSR funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI. Other codes are invalid.
- `addr_i`  in  12  CSR address.
- `rs1_data_i`  in  32  register source operand.
- `zimm_i`  in  5  immediate source operand, zero-extended.
- `we_i`  in  1  CSR instruction executing this cycle.
- `pc_i`  in  32  PC of the current instruction.
- `trap_i`  in  1  interrupt taken this cycle.
- `mcause_i`  in  32  cause code from the interrupt controller.
- `mret_i`  in  1  `mret` executing this cycle.
- `rdata_o`  out  32  old value of the addressed CSR.
- `illegal_o`  out  1  `we_i` with an unimplemented address or an invalid `op_i`.
- `mie_o`  out  32  `mie` register, to the interrupt controller.
- `mstatus_mie_o`  out  1  global interrupt enable (`mstatus.MIE`).
- `mtvec_o`  out  32  trap vector (next PC on trap).
- `mepc_o`  out  32  return address (next PC on `mret`).
- `int_rst_o`  out  1  acknowledge pulse to the interrupt controller.

## Operation
Implemented CSRs. All reset to 0 except `mtvec`.
- `mstatus` 0x300: only bit 3 (MIE) and bit 7 (MPIE) are stored. All other bits read 0.
- `mie` 0x304: full 32 bits.
- `mtvec` 0x305: direct mode only. Bits [1:0] are forced to 0 on write.
- `mscratch` 0x340: full 32 bits.
- `mepc` 0x341: bits [1:0] are forced to 0 on write.
- `mcause` 0x342: full 32 bits.

Reads and illegal accesses:
- Any other address reads 0 and ignores writes.
- `rdata_o` is combinational and always returns the pre-update value.

Write data:
- Source `src` is `rs1_data_i` for RW/RS/RC, and `{27'b0, zimm_i}` for the immediate forms.
- RW: `new = src`.
- RS: `new = old | src`.
- RC: `new = old & ~src`.
- RS/RC with `src = 0` still perform the write. There is no side effect.

Events and priority:
- Trap (`trap_i`):
  - `mepc <= pc_i & ~3`.
  - `mcause <= mcause_i`.
  - `MPIE <= MIE`, then `MIE <= 0`.
  - Any CSR write in the same cycle is suppressed, because the instruction does not retire.
- `mret_i`:
  - `MIE <= MPIE`, `MPIE <= 1`.
  - `int_rst_o = mret_i & ~trap_i`, combinational, one cycle.
- `trap_i` together with `mret_i`: the trap wins and `mret` has no effect.
- `we_i` together with `mret_i`: the CSR write applies. If it targets `mstatus`, the `mret` update of MIE/MPIE overrides the written bits.
- `illegal_o` is combinational and only high when `we_i` is high. No state changes when it is high.

## Timing
- Single-cycle core: `rdata_o`, `illegal_o` and `int_rst_o` are combinational from the current inputs.
- All register updates are visible on the cycle after the edge.
- `mtvec_o`, `mepc_o`, `mie_o` and `mstatus_mie_o` come directly from the registers, with no bypass.
- A write to `mepc` followed by `mret` in the next cycle returns to the new value.
- Reset applies mid-operation on the next posedge, regardless of `trap_i`, `mret_i` or `we_i`.
- Reset values of the outputs:
  - `mie_o` = 0, `mstatus_mie_o` = 0, `mepc_o` = 0.
  - `mtvec_o` = `MTVEC_RST & ~3`.
  - `rdata_o` and `illegal_o` follow their inputs. `int_rst_o` follows `mret_i`.

## Structure
- Shared package `csr_pkg`:
  - CSR address localparams.
  - `op_i` encodings as an enum.
  - `mstatus` bit indices (MIE = 3, MPIE = 7).
  - Function `csr_wdata(op, old, src)`.
- No sub-module. The design is a single flat module: a read mux, the write-data function, and per-register always_ff blocks with the priority trap > CSR write, plus the `mret` override on `mstatus`.

## Test plan
- Reset, then read every implemented CSR.
  - Expect 0, except `mtvec` = `MTVEC_RST & ~3`.
  - Expect `illegal_o` = 1 on 0x7C0 with `we_i` = 1.
- CSRRW `mie` with 32'hFFFF_0F0F, then CSRRS with 32'h0000_00F0, then CSRRC with 32'h0F00_0000.
  - `rdata_o` returns the old values: 0, FFFF0F0F, FFFF0FFF.
  - `mie_o` ends at F0FF0FFF.
- CSRRSI `mstatus` with zimm = 8, giving `mstatus_mie_o` = 1. Then `trap_i` with `pc_i` = 32'h0000_0123 and `mcause_i` = 5, with `we_i` = 1 to `mscratch`. Expect:
  - `mepc` = 0x120, `mcause` = 5.
  - `mstatus` = 0x80.
  - `mscratch` unchanged.
- `mret_i` after the trap above. Expect:
  - `int_rst_o` = 1 for that cycle only.
  - `mstatus` = 0x88 on the next cycle.
- `trap_i` and `mret_i` in the same cycle with MIE = 1. Expect:
  - `int_rst_o` = 0.
  - `mstatus` = 0x80.
  - `mepc` = `pc_i & ~3`.
- Write `mtvec` = 32'h0000_1003. Expect `mtvec_o` = 32'h0000_1000.
